bin_window_gen: RTL and testbench

BIN_WINDOW_GEN -- requirements
Module: bin_window_gen

---
 rtl/bin_window_gen.sv | 127 ++++++++++++
 tb/tb_bin_window_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_window_gen.sv
// ----------------------------------------------------------------------------
// bin_window_gen
//   Turns a raster-ordered stream of binarized pooled pixels into 3x3 binary
//   windows for the following binary-convolution layer. Two IMG_W-bit line
//   buffers hold the two previous rows; a 3x3 shift window is fed with
//   {line1 out, line0 out, din} on every accepted pixel. A window is emitted
//   only when it lies entirely inside the current frame (row>=2, col>=2).
//
// Ports
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset
//   state      : layer active; 0 synchronously clears counters and outputs
//   ivalid     : din qualifier
//   din        : binarized pixel, row-major raster order
//   ovalid     : one-cycle pulse, window is valid
//   window     : 3x3 window, window[8-(3*r+c)] = pixel(row-2+r, col-2+c)
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
// ----------------------------------------------------------------------------
module bin_window_gen #(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       state,
    input  logic       ivalid,
    input  logic       din,
    output logic       ovalid,
    output logic [8:0] window,
    output logic       frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [IMG_W-1:0] line0_q, line0_d;   // previous row
    logic [IMG_W-1:0] line1_q, line1_d;   // row before that
    logic [8:0]       shw_q, shw_d;       // free-running shift window
    logic [8:0]       win_q, win_d;       // published window (held between pulses)
    logic             ovalid_q, ovalid_d;
    logic             fdone_q, fdone_d;

    logic       accept;
    logic       col_last, row_last;
    logic       l0_out, l1_out;
    logic [8:0] shw_nxt;

    assign accept   = state & ivalid;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));

    // Oldest bit of each line buffer is the pixel directly above (same col).
    assign l0_out = line0_q[IMG_W-1];
    assign l1_out = line1_q[IMG_W-1];

    // Each window row is 3 bits {c0,c1,c2}; shifting left drops c0 and
    // appends the new right-hand column (top: row-2, mid: row-1, bottom: din).
    assign shw_nxt = {shw_q[7:6], l1_out,
                      shw_q[4:3], l0_out,
                      shw_q[1:0], din};

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        line0_d  = line0_q;
        line1_d  = line1_q;
        shw_d    = shw_q;
        win_d    = win_q;
        ovalid_d = 1'b0;
        fdone_d  = 1'b0;

        if (!state) begin
            // Layer idle: restart at (0,0). Line buffers keep stale data; the
            // row>=2 gate guarantees it never reaches an emitted window.
            col_d = '0;
            row_d = '0;
            shw_d = '0;
            win_d = '0;
        end else if (accept) begin
            line0_d = {line0_q[IMG_W-2:0], din};
            line1_d = {line1_q[IMG_W-2:0], l0_out};
            shw_d   = shw_nxt;

            if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                ovalid_d = 1'b1;
                win_d    = shw_nxt;
            end
            fdone_d = row_last & col_last;

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q    <= '0;
            row_q    <= '0;
            line0_q  <= '0;
            line1_q  <= '0;
            shw_q    <= '0;
            win_q    <= '0;
            ovalid_q <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            line0_q  <= line0_d;
            line1_q  <= line1_d;
            shw_q    <= shw_d;
            win_q    <= win_d;
            ovalid_q <= ovalid_d;
            fdone_q  <= fdone_d;
        end
    end

    assign ovalid     = ovalid_q;
    assign window     = win_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_bin_window_gen.sv
// ----------------------------------------------------------------------------
// tb_bin_window_gen
//   Directed bench for bin_window_gen at default 12x12. Pixel images are
//   built in the bench; each expected window is read straight out of the
//   image at (row-2..row, col-2..col).
// ----------------------------------------------------------------------------
module tb_bin_window_gen;

    localparam int W = 12;
    localparam int H = 12;

    logic       clk = 1'b0;
    logic       rstn, state, ivalid, din;
    logic       ovalid, frame_done;
    logic [8:0] window;

    bin_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .state      (state),
        .ivalid     (ivalid),
        .din        (din),
        .ovalid     (ovalid),
        .window     (window),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    bit         img [H][W];
    logic [8:0] wins [H][W];
    logic [8:0] last_win;
    int         ov_cnt, fd_cnt, nz_cnt, pix_idx, first_ov;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [8:0] expwin(input int r, input int c);
        logic [8:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[8-(3*dr+dc)] = img[r-2+dr][c-2+dc];
        return w;
    endfunction

    task automatic clr_stats();
        ov_cnt = 0; fd_cnt = 0; nz_cnt = 0; pix_idx = 0; first_ov = -1;
    endtask

    // Present pixel (r,c) for one edge, then check the registered result.
    task automatic push(input int r, input int c);
        bit exp_ov;
        state  = 1'b1;
        ivalid = 1'b1;
        din    = img[r][c];
        @(posedge clk); #1;
        ivalid = 1'b0;
        exp_ov = (r >= 2 && c >= 2);
        chk($sformatf("ovalid(%0d,%0d)", r, c), ovalid, exp_ov);
        chk($sformatf("fdone(%0d,%0d)", r, c), frame_done, (r == H-1 && c == W-1));
        if (ovalid) begin
            ov_cnt++;
            if (first_ov < 0) first_ov = pix_idx;
            if (window != 0) nz_cnt++;
            wins[r][c] = window;
            last_win   = window;
        end
        if (frame_done) fd_cnt++;
        if (exp_ov) chk($sformatf("win(%0d,%0d)", r, c), window, expwin(r, c));
        pix_idx++;
    endtask

    // Idle cycles with state=1, ivalid=0: nothing may move.
    task automatic gap(input int n);
        ivalid = 1'b0;
        din    = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("gap_ovalid", ovalid, 1'b0);
            chk("gap_fdone", frame_done, 1'b0);
            chk("gap_win_hold", window, last_win);
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
                push(r, c);
            end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ovalid"}, ovalid, 1'b0);
        chk({tag, "_fdone"}, frame_done, 1'b0);
        chk({tag, "_win"}, window, 9'h000);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rstn = 1'b0; state = 1'b0; ivalid = 1'b0; din = 1'b0;
        last_win = '0;
        clr_stats();
        #12;
        chk_zero("reset");
        @(negedge clk); rstn = 1'b1;

        // Checkerboard (row+col)&1, contiguous.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 1'((r + c) & 1);
        clr_stats();
        send_frame(1'b0);
        chk("cb_ov_cnt", ov_cnt, 100);
        chk("cb_fd_cnt", fd_cnt, 1);
        chk("cb_first_ov_idx", first_ov, 26);
        // (2,2): rows 010/101/010 -> 0_1010_1010; one step right flips parity.
        chk("cb_win_2_2", wins[2][2], 9'h0AA);
        chk("cb_win_2_3", wins[2][3], 9'h155);

        // All ones with random ivalid gaps.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 1'b1;
        clr_stats();
        send_frame(1'b1);
        chk("ones_ov_cnt", ov_cnt, 100);
        chk("ones_fd_cnt", fd_cnt, 1);
        chk("ones_win_11_11", wins[11][11], 9'h1FF);

        // Single 1 at (5,5).
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 1'b0;
        img[5][5] = 1'b1;
        clr_stats();
        send_frame(1'b0);
        chk("dot_ov_cnt", ov_cnt, 100);
        chk("dot_nz_cnt", nz_cnt, 9);
        chk("dot_win_5_5", wins[5][5], 9'h001);
        chk("dot_win_7_7", wins[7][7], 9'h100);
        chk("dot_win_6_6", wins[6][6], 9'h010);

        // Drop state after 60 pixels, then a fresh frame.
        fill_rand();
        clr_stats();
        for (int i = 0; i < 60; i++) push(i / W, i % W);
        state = 1'b0; ivalid = 1'b1; din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_zero("drop");
        end
        last_win = '0;
        fill_rand();
        clr_stats();
        send_frame(1'b0);
        chk("drop_ov_cnt", ov_cnt, 100);
        chk("drop_fd_cnt", fd_cnt, 1);

        // Asynchronous reset pulse after 30 pixels.
        fill_rand();
        clr_stats();
        for (int i = 0; i < 30; i++) push(i / W, i % W);
        #2 rstn = 1'b0;
        #1 chk_zero("rst_async");
        ivalid = 1'b1; din = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_zero("rst_hold");
        end
        ivalid = 1'b0;
        @(negedge clk); rstn = 1'b1;
        last_win = '0;
        fill_rand();
        clr_stats();
        send_frame(1'b0);
        chk("rst_ov_cnt", ov_cnt, 100);
        chk("rst_fd_cnt", fd_cnt, 1);

        // Two back-to-back random frames, no idle between them.
        clr_stats();
        fill_rand();
        send_frame(1'b0);
        fill_rand();
        send_frame(1'b0);
        chk("b2b_ov_cnt", ov_cnt, 200);
        chk("b2b_fd_cnt", fd_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
